// File: rtl/reaction_pkg.sv
// reaction_pkg: shared FSM states, count width and Galois LFSR step for the reaction-time controller
package reaction_pkg;

    localparam int MS_W = 14;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_GO   = 3'd2,
        S_DONE = 3'd3,
        S_FOUL = 3'd4
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/reaction_lfsr.sv
// reaction_lfsr: free-running 16-bit Galois LFSR (taps 16,14,13,11), low OUT_W bits exposed
module reaction_lfsr
    import reaction_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    output logic [OUT_W-1:0] rnd
);

    logic [15:0] lfsr_q;

    // the all-zero lockup state is unreachable from a nonzero seed, but reload defensively
    always_ff @(posedge clk_in or posedge rst)
        if (rst)
            lfsr_q <= SEED;
        else if (en)
            lfsr_q <= (lfsr_q == '0) ? SEED : lfsr_next(lfsr_q);

    assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: one reaction-time trial (arm, random hold-off, GO, ms count); REACTION_BEST_EN adds best_ms
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 11,
    parameter int          MAX_MS       = 9999,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic            ms_clk,
    input  logic            btn_press,
    output logic            go_led,
    output logic [MS_W-1:0] time_ms,
    output logic            time_valid,
    output logic            false_start,
    output logic            busy
`ifdef REACTION_BEST_EN
    ,
    output logic [MS_W-1:0] best_ms
`endif
);

    localparam int DW = $clog2(MIN_DELAY_MS + 2**RAND_BITS);

    state_t                 state;
    logic [2:0]             ms_sync;
    logic                   ms_tick;
    logic [RAND_BITS-1:0]   rnd;
    logic [DW-1:0]          delay_cnt;
    logic [MS_W-1:0]        ms_cnt;

    // two flops resynchronise the divider output, the third gives the rising-edge strobe
    always_ff @(posedge clk_in or posedge rst)
        if (rst)
            ms_sync <= '0;
        else
            ms_sync <= {ms_sync[1:0], ms_clk};

    assign ms_tick = ms_sync[1] & ~ms_sync[2];

    reaction_lfsr #(.SEED(LFSR_SEED), .OUT_W(RAND_BITS)) u_lfsr (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (1'b1),
        .rnd    (rnd)
    );

    // a press always takes priority over a coincident tick
    always_ff @(posedge clk_in or posedge rst)
        if (rst) begin
            state     <= S_IDLE;
            delay_cnt <= '0;
            ms_cnt    <= '0;
            time_ms   <= '0;
        end else begin
            case (state)
                S_IDLE:
                    if (btn_press) begin
                        state     <= S_WAIT;
                        delay_cnt <= DW'(MIN_DELAY_MS) + DW'(rnd);
                    end
                S_WAIT:
                    if (btn_press)
                        state <= S_FOUL;
                    else if (ms_tick) begin
                        if (delay_cnt == DW'(1)) begin
                            state  <= S_GO;
                            ms_cnt <= '0;
                        end else
                            delay_cnt <= delay_cnt - DW'(1);
                    end
                S_GO:
                    if (btn_press) begin
                        state   <= S_DONE;
                        time_ms <= ms_cnt;
                    end else if (ms_tick && ms_cnt < MS_W'(MAX_MS))
                        ms_cnt <= ms_cnt + MS_W'(1);
                S_DONE, S_FOUL:
                    if (btn_press)
                        state <= S_IDLE;
                default:
                    state <= S_IDLE;
            endcase
        end

`ifdef REACTION_BEST_EN
    always_ff @(posedge clk_in or posedge rst)
        if (rst)
            best_ms <= MS_W'(MAX_MS);
        else if (state == S_GO && btn_press && ms_cnt < best_ms)
            best_ms <= ms_cnt;
`endif

    assign go_led      = (state == S_GO);
    assign time_valid  = (state == S_DONE);
    assign false_start = (state == S_FOUL);
    assign busy        = (state == S_WAIT) || (state == S_GO);

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl: randomized trials scored against a queue of expected DONE/FOUL results
module tb_reaction_ctrl;

    localparam int MAXV = 9999;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        ms_clk = 1'b0;
    logic        btn_press = 1'b0;
    logic        go_led, time_valid, false_start, busy;
    logic [13:0] time_ms;
`ifdef REACTION_BEST_EN
    logic [13:0] best_ms;
`endif

    typedef struct {
        bit foul;
        int t;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   last_time = 0;
    bit   done = 1'b0;

    reaction_ctrl #(.MIN_DELAY_MS(5), .RAND_BITS(2), .MAX_MS(MAXV), .LFSR_SEED(16'hACE1)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .ms_clk      (ms_clk),
        .btn_press   (btn_press),
        .go_led      (go_led),
        .time_ms     (time_ms),
        .time_valid  (time_valid),
        .false_start (false_start),
        .busy        (busy)
`ifdef REACTION_BEST_EN
        ,
        .best_ms     (best_ms)
`endif
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic tick();
        ms_clk = 1'b1;
        cyc(2);
        ms_clk = 1'b0;
        cyc(2);
    endtask

    task automatic press();
        btn_press = 1'b1;
        cyc(1);
        btn_press = 1'b0;
        cyc(1);
    endtask

    // press lands in the same cycle as the synchronised tick strobe
    task automatic tick_press();
        ms_clk = 1'b1;
        cyc(2);
        ms_clk = 1'b0;
        btn_press = 1'b1;
        cyc(1);
        btn_press = 1'b0;
        cyc(1);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        last_time = 0;
    endtask

    task automatic to_go(output int d);
        press();
        check("busy_in_wait", busy, 1);
        d = 0;
        while (!go_led && d < 12) begin
            tick();
            d++;
        end
        check("go_delay_5_to_8", int'(d >= 5 && d <= 8), 1);
        check("go_led_on", go_led, 1);
    endtask

    task automatic finish_trial(input int n);
        exp_t e;
        repeat (n) tick();
        e.foul = 1'b0;
        e.t = (n > MAXV) ? MAXV : n;
        sb.push_back(e);
        last_time = e.t;
        press();
        check("go_off_in_done", go_led, 0);
        press();
        check("valid_cleared", time_valid, 0);
        check("time_held_idle", time_ms, last_time);
    endtask

    task automatic run_trial(input int n);
        int d;
        cyc($urandom_range(0, 7));
        to_go(d);
        finish_trial(n);
    endtask

    task automatic foul_trial(input int m);
        exp_t e;
        cyc($urandom_range(0, 7));
        press();
        repeat (m) begin
            tick();
            check("no_go_in_wait", go_led, 0);
        end
        e.foul = 1'b1;
        e.t = last_time;
        sb.push_back(e);
        press();
        check("false_start_set", false_start, 1);
        check("go_never_on", go_led, 0);
        press();
        check("false_start_cleared", false_start, 0);
        check("idle_not_busy", busy, 0);
    endtask

    initial begin
        fork
            begin : stimulus
                int   d;
                exp_t e;
                cyc(1);
                check("rst_go_led", go_led, 0);
                check("rst_time_valid", time_valid, 0);
                check("rst_false_start", false_start, 0);
                check("rst_busy", busy, 0);
                check("rst_time_ms", time_ms, 0);
`ifdef REACTION_BEST_EN
                check("rst_best_ms", best_ms, MAXV);
`endif
                rst = 1'b0;
                cyc(1);
                run_trial(123);
                foul_trial(2);
                // asynchronous reset in the middle of GO
                to_go(d);
                repeat (37) tick();
                rst = 1'b1;
                #1;
                check("async_rst_go_led", go_led, 0);
                check("async_rst_busy", busy, 0);
                check("async_rst_time_ms", time_ms, 0);
                cyc(1);
                rst = 1'b0;
                last_time = 0;
                cyc(1);
                press();
                check("post_rst_wait_busy", busy, 1);
                check("post_rst_wait_go", go_led, 0);
                reset_dut();
                // press coincident with a tick in GO is not counted
                to_go(d);
                repeat (50) tick();
                e.foul = 1'b0;
                e.t = 50;
                sb.push_back(e);
                last_time = 50;
                tick_press();
                check("coinc_go_done", time_valid, 1);
                press();
                // measure the hold-off, then replay identical timing with a press on the expiring tick
                reset_dut();
                cyc(3);
                to_go(d);
                finish_trial(0);
                reset_dut();
                cyc(3);
                press();
                repeat (d - 1) begin
                    tick();
                    check("replay_no_go", go_led, 0);
                end
                e.foul = 1'b1;
                e.t = 0;
                sb.push_back(e);
                tick_press();
                check("expiry_coinc_foul", false_start, 1);
                check("expiry_coinc_no_go", go_led, 0);
                press();
                repeat (3) run_trial($urandom_range(0, 300));
                foul_trial($urandom_range(0, 4));
                run_trial(10005);
`ifdef REACTION_BEST_EN
                reset_dut();
                check("best_after_rst", best_ms, MAXV);
                run_trial(300);
                run_trial(200);
                run_trial(250);
                check("best_min", best_ms, 200);
                foul_trial(2);
                check("best_after_foul", best_ms, 200);
`endif
                cyc(4);
                done = 1'b1;
            end
            begin : monitor
                bit   pv = 1'b0;
                bit   pf = 1'b0;
                exp_t e;
                while (!done) begin
                    @(negedge clk_in);
                    if ((time_valid && !pv) || (false_start && !pf)) begin
                        if (sb.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_event actual=tv%0d/fs%0d required=none", time_valid, false_start);
                        end else begin
                            e = sb.pop_front();
                            check("event_is_foul", false_start, int'(e.foul));
                            check("event_time_ms", time_ms, e.t);
                        end
                    end
                    pv = time_valid;
                    pf = false_start;
                end
            end
        join
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
